// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte write handshake between the MMIO write path and the UART TX.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                      wr_valid;
    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered UART transmitter: FIFO + 8N1 serialiser.
// Define UART_TX_PARITY_EN for even parity (8E1).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 434,
    parameter  int FIFO_DEPTH   = 8,
    localparam int CW           = $clog2(FIFO_DEPTH + 1),
    localparam int BW           = $clog2(CLKS_PER_BIT)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_ctrl_if.slave       wr,
    output logic                tx,
    output logic                busy,
    output logic [CW-1:0]       fifo_count
);

    localparam int DW = UART_DATA_BITS;

    uart_tx_state_e state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           baud_last;
    logic           load;
    logic           fifo_pop, fifo_push;
    logic           fifo_full, fifo_empty;
    logic [DW-1:0]  fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    // ready depends only on the registered count, never on a same-cycle pop
    assign wr.wr_ready = !fifo_full;
    assign fifo_push   = wr.wr_valid && !fifo_full;
    assign baud_last   = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign tx          = tx_q;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr.wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        load     = 1'b0;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                load   = !fifo_empty;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    load    = !fifo_empty;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
            baud_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d    = ^fifo_dout;
`endif
        end
    end

    // line level follows the state one cycle later through the tx register
    always_comb begin
        tx_d = UART_IDLE_LVL;
        unique case (state_q)
            ST_IDLE:   tx_d = UART_IDLE_LVL;
            ST_START:  tx_d = UART_START_LVL;
            ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            ST_STOP:   tx_d = UART_STOP_LVL;
            default:   tx_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench: accepted bytes queue up, a model receiver decodes tx.
// Honours UART_TX_PARITY_EN (8E1 frames) when defined.
module tb_uart_tx_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_ctrl_if wr_if ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_if),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    int         frame_starts[$];

    bit         rx_active = 0;
    int         rx_t;
    logic [7:0] rx_byte;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model receiver: samples the middle of every bit slot of a frame.
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 0;
        end else begin
            if (!rx_active && tx === 1'b0) begin
                rx_active = 1;
                rx_t      = -1;
                frame_starts.push_back(cyc);
            end
            if (rx_active) begin
                int slot;
                rx_t++;
                slot = rx_t / CPB;
                if (rx_t % CPB == CPB / 2) begin
                    if (slot == 0) begin
                        chk("start_bit", tx, 0);
                    end else if (slot <= 8) begin
                        rx_byte[slot-1] = tx;
`ifdef UART_TX_PARITY_EN
                    end else if (slot == 9) begin
                        chk("parity_bit", tx, ^rx_byte);
`endif
                    end else begin
                        chk("stop_bit", tx, 1);
                        chk("frame_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0)
                            chk("rx_byte", rx_byte, exp_q.pop_front());
                    end
                end
                if (rx_t == FRAME - 1) rx_active = 0;
            end
        end
    end

    task automatic drive_cycle(input bit v, input logic [7:0] d,
                               input bit chk_rdy, output bit acc);
        @(negedge clk);
        wr_if.wr_valid = v;
        wr_if.wr_data  = d;
        acc = v && wr_if.wr_ready;
        if (chk_rdy)
            chk("wr_ready_vs_count", wr_if.wr_ready,
                fifo_count != 4'(DEPTH));
        @(posedge clk);
        if (acc) exp_q.push_back(d);
    endtask

    task automatic push1(input logic [7:0] d);
        bit acc;
        drive_cycle(1, d, 0, acc);
        chk("push_accepted", acc, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive_cycle(0, 8'h00, 0, acc);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            wr_if.wr_valid = 0;
            if (!busy && !rx_active) done = 1;
            else @(posedge clk);
        end
        chk("idle_reached", done, 1);
    endtask

    initial begin
        int n0;
        int nacc;
        int maxc;
        bit acc;

        rst            = 1;
        wr_if.wr_valid = 0;
        wr_if.wr_data  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_wr_ready", wr_if.wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_count", fifo_count, 0);
        rst = 0;
        idle(2);

        // single byte latency and framing
        push1(8'hA5);
        @(negedge clk);
        wr_if.wr_valid = 0;
        chk("lat_e0_count", fifo_count, 1);
        chk("lat_e0_tx", tx, 1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e1_tx", tx, 1);
        chk("lat_e1_count", fifo_count, 0);
        chk("lat_e1_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e2_tx", tx, 0);
        wait_idle(FRAME + 10);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        // back-to-back frames
        n0 = frame_starts.size();
        push1(8'h00);
        push1(8'hFF);
        push1(8'h55);
        wait_idle(3 * FRAME + 20);
        chk("b2b_frames", frame_starts.size() - n0, 3);
        if (frame_starts.size() - n0 == 3) begin
            for (int i = 0; i < 2; i++)
                chk("b2b_gap",
                    frame_starts[n0+i+1] - frame_starts[n0+i], FRAME);
        end

        // hold valid for 12 cycles: 1 in flight + DEPTH queued
        nacc = 0;
        maxc = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, 8'($urandom), 1, acc);
            if (acc) nacc++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        chk("fill_accepted", nacc, DEPTH + 1);
        chk("fill_max_count", maxc, DEPTH);
        wait_idle((DEPTH + 2) * FRAME + 20);

        // push on the last STOP cycle while the final byte is popped
        push1(8'h3C);
        push1(8'hC3);
        idle(FRAME - 1);
        push1(8'h5A);
        @(negedge clk);
        wr_if.wr_valid = 0;
        chk("stop_push_count", fifo_count, 1);
        wait_idle(3 * FRAME + 20);

        // randomized bytes with random gaps
        for (int i = 0; i < 8; i++) begin
            push1(8'($urandom));
            idle($urandom_range(0, FRAME + 4));
        end
`ifdef UART_TX_PARITY_EN
        push1(8'h07);
        push1(8'h03);
`endif
        wait_idle((DEPTH + 2) * FRAME + 20);
        chk("scoreboard_drained", exp_q.size(), 0);

        // reset in the middle of DATA with 3 bytes queued
        push1(8'h11);
        push1(8'h22);
        push1(8'h33);
        push1(8'h44);
        idle(2 * CPB + 2);
        @(negedge clk);
        chk("pre_rst_count", fifo_count, 3);
        rst = 1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        n0 = frame_starts.size();
        idle(2 * FRAME);
        chk("post_rst_no_frames", frame_starts.size() - n0, 0);
        chk("post_rst_tx", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
